// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front-end.
// Provides defaults, id width calculation and the round-robin picker.
package btn_pkg;

    localparam int DEF_N_BTN    = 4;
    localparam int DEF_DB_LEN   = 4;
    localparam int DEF_TICK_DIV = 100000;
    localparam int MAX_BTN      = 8;
    localparam int MAX_ID_W     = 3;

    // Width of a button index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of pend strictly after last, wrapping at n.
    // Walks from the farthest offset to the nearest so the nearest
    // pending index is the one left standing.
    function automatic int rr_select(
        input logic [MAX_BTN-1:0] pend,
        input int                 n,
        input int                 last
    );
        int idx;
        int res;
        res = last;
        for (int k = MAX_BTN; k >= 1; k--) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (pend[idx[MAX_ID_W-1:0]]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One button: 2-flop sync, tick-sampled debounce history, level, rise pulse.
// Ports: clk, rst_n, tick (shared sample strobe), btn_raw, level, edge_p.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_LEN = DEF_DB_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic edge_p
);

    logic              sync1;
    logic              sync2;
    logic              level_d;
    logic [DB_LEN-1:0] hist;
    logic [DB_LEN-1:0] hist_nxt;

    assign hist_nxt = {hist[DB_LEN-2:0], sync2};

    // Level decides on the shifted-in history so it changes on the
    // same tick that completes the run of agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            hist    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            edge_p  <= 1'b0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            if (tick) begin
                hist <= hist_nxt;
                if (&hist_nxt) begin
                    level <= 1'b1;
                end else if (~|hist_nxt) begin
                    level <= 1'b0;
                end
            end
            level_d <= level;
            edge_p  <= level & ~level_d;
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button front-end: conditions each button, queues presses as pending
// bits and round-robins them onto one valid/ready event port.
// Ports: clk, rst_n, btn_in, evt_valid/evt_id/evt_ready (event port),
//        evt_overrun (dropped-press pulses), btn_level (debounced levels).
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN    = DEF_N_BTN,
    parameter int DB_LEN   = DEF_DB_LEN,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    output logic [id_w(N_BTN)-1:0]   evt_id,
    input  logic                     evt_ready,
    output logic [N_BTN-1:0]         evt_overrun,
    output logic [N_BTN-1:0]         btn_level
);

    localparam int ID_W  = id_w(N_BTN);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [N_BTN-1:0]   edge_p;
    logic [N_BTN-1:0]   pend;
    logic [N_BTN-1:0]   grant_oh;
    logic [MAX_BTN-1:0] pend_ext;
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    sel_id;
    logic               load;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_conditioner #(
            .DB_LEN (DB_LEN)
        ) u_cond (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .btn_raw (btn_in[i]),
            .level   (btn_level[i]),
            .edge_p  (edge_p[i])
        );
    end

    always_comb begin
        pend_ext             = '0;
        pend_ext[N_BTN-1:0]  = pend;
        sel_id   = ID_W'(rr_select(pend_ext, N_BTN, int'(last_id)));
        load     = (~evt_valid | evt_ready) & (|pend);
        grant_oh = '0;
        if (load) grant_oh[sel_id] = 1'b1;
    end

    // A granted bit is cleared unless a fresh edge re-arms it in the
    // same cycle; an edge on a bit that stays set is a lost press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            evt_overrun <= '0;
        end else begin
            pend        <= (pend & ~grant_oh) | edge_p;
            evt_overrun <= edge_p & pend & ~grant_oh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            last_id   <= ID_W'(N_BTN - 1);
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_id    <= sel_id;
            last_id   <= sel_id;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter (N_BTN=4, DB_LEN=3, TICK_DIV=4).
// Scenario tasks plus a randomized press/conservation check.
module tb_btn_event_arbiter;

    localparam int N  = 4;
    localparam int DB = 3;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = '0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] evt_overrun;
    logic [3:0] btn_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   ev_ids[$];
    int   ev_cyc[$];
    int   ovr_cnt[4];
    int   stall_viol = 0;
    logic prev_stall = 1'b0;
    logic [1:0] prev_id = '0;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN    (N),
        .DB_LEN   (DB),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .evt_overrun (evt_overrun),
        .btn_level   (btn_level)
    );

    // cyc = number of clock edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Transfer / overrun / stall-stability monitor (pre-edge values)
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!evt_valid || evt_id !== prev_id))
                stall_viol++;
            if (evt_valid && evt_ready) begin
                ev_ids.push_back(int'(evt_id));
                ev_cyc.push_back(cyc);
            end
            for (int i = 0; i < 4; i++)
                if (evt_overrun[i]) ovr_cnt[i]++;
            prev_stall = evt_valid & ~evt_ready;
            prev_id    = evt_id;
        end
    end

    function automatic int ceil4(input int x);
        return ((x + 3) / 4) * 4;
    endfunction

    function automatic int count_id(input int from, input int id);
        int c = 0;
        for (int k = from; k < ev_ids.size(); k++)
            if (ev_ids[k] == id) c++;
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    // Raise button b now; return edge at which its level should rise:
    // sync takes 2 edges, then three sample ticks (every 4th edge).
    task automatic press_at(input int b, output int n3);
        btn_in[b] = 1'b1;
        n3 = ceil4(cyc + 1 + 2) + 8;
    endtask

    task automatic click(input int b);
        btn_in[b] = 1'b1;
        idle(20);
        btn_in[b] = 1'b0;
        idle(20);
    endtask

    task automatic test_reset();
        apply_reset();
        idle(2);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", evt_valid);
        end
        checks++;
        if (evt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_id got %0d want 0", evt_id);
        end
        checks++;
        if (evt_overrun !== 4'h0) begin
            errors++;
            $display("FAIL reset_overrun got %h want 0", evt_overrun);
        end
        checks++;
        if (btn_level !== 4'h0) begin
            errors++;
            $display("FAIL reset_level got %h want 0", btn_level);
        end
    endtask

    task automatic test_clean_press();
        int n3;
        int base;
        apply_reset();
        evt_ready = 1'b1;
        idle(5);
        base = ev_ids.size();
        press_at(2, n3);
        wait_until(n3 - 1);
        checks++;
        if (btn_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_early got %b want 0", btn_level[2]);
        end
        @(negedge clk);
        checks++;
        if (btn_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_rise got %b want 1", btn_level[2]);
        end
        wait_until(n3 + 10);
        checks++;
        if (ev_ids.size() != base + 1) begin
            errors++;
            $display("FAIL clean_count got %0d want 1", ev_ids.size() - base);
        end else begin
            checks++;
            if (ev_ids[base] != 2 || ev_cyc[base] != n3 + 3) begin
                errors++;
                $display("FAIL clean_event got id %0d cyc %0d want id 2 cyc %0d",
                         ev_ids[base], ev_cyc[base], n3 + 3);
            end
        end
        btn_in[2] = 1'b0;
        idle(40);
        checks++;
        if (ev_ids.size() != base + 1) begin
            errors++;
            $display("FAIL clean_release got %0d events want 1",
                     ev_ids.size() - base);
        end
    endtask

    task automatic test_bounce();
        int base;
        apply_reset();
        evt_ready = 1'b1;
        idle(5);
        base = ev_ids.size();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn_in[1] = ~btn_in[1];
            @(negedge clk);
        end
        checks++;
        if (ev_ids.size() != base) begin
            errors++;
            $display("FAIL bounce_quiet got %0d events want 0",
                     ev_ids.size() - base);
        end
        btn_in[1] = 1'b1;
        idle(30);
        checks++;
        if (ev_ids.size() != base + 1 || count_id(base, 1) != 1) begin
            errors++;
            $display("FAIL bounce_event got %0d events (%0d id1) want 1",
                     ev_ids.size() - base, count_id(base, 1));
        end
        btn_in[1] = 1'b0;
        idle(30);
    endtask

    task automatic test_round_robin();
        int n3;
        int base;
        apply_reset();
        idle(3);
        btn_in = 4'b1011;
        n3 = ceil4(cyc + 1 + 2) + 8;
        wait_until(n3 + 3);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rr_first got v%b id %0d want v1 id 0",
                     evt_valid, evt_id);
        end
        idle(15);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rr_stall got v%b id %0d want v1 id 0",
                     evt_valid, evt_id);
        end
        base = ev_ids.size();
        evt_ready = 1'b1;
        idle(6);
        checks++;
        if (ev_ids.size() != base + 3) begin
            errors++;
            $display("FAIL rr_count got %0d want 3", ev_ids.size() - base);
        end else begin
            checks++;
            if (ev_ids[base] != 0 || ev_ids[base+1] != 1 ||
                ev_ids[base+2] != 3) begin
                errors++;
                $display("FAIL rr_order got %0d %0d %0d want 0 1 3",
                         ev_ids[base], ev_ids[base+1], ev_ids[base+2]);
            end
            checks++;
            if (ev_cyc[base+1] != ev_cyc[base] + 1 ||
                ev_cyc[base+2] != ev_cyc[base] + 2) begin
                errors++;
                $display("FAIL rr_b2b got cyc %0d %0d %0d want consecutive",
                         ev_cyc[base], ev_cyc[base+1], ev_cyc[base+2]);
            end
        end
        btn_in = '0;
        idle(30);
    endtask

    task automatic test_overrun();
        int base;
        int o[4];
        apply_reset();
        idle(3);
        base = ev_ids.size();
        for (int i = 0; i < 4; i++) o[i] = ovr_cnt[i];
        click(2);
        click(2);
        click(2);
        checks++;
        if (ovr_cnt[2] - o[2] != 1) begin
            errors++;
            $display("FAIL ovr_pulse got %0d want 1", ovr_cnt[2] - o[2]);
        end
        checks++;
        if (ovr_cnt[0] != o[0] || ovr_cnt[1] != o[1] || ovr_cnt[3] != o[3]) begin
            errors++;
            $display("FAIL ovr_other got %0d %0d %0d want 0 0 0",
                     ovr_cnt[0] - o[0], ovr_cnt[1] - o[1], ovr_cnt[3] - o[3]);
        end
        checks++;
        if (ev_ids.size() != base) begin
            errors++;
            $display("FAIL ovr_stalled got %0d events want 0",
                     ev_ids.size() - base);
        end
        evt_ready = 1'b1;
        idle(10);
        checks++;
        if (ev_ids.size() != base + 2 || count_id(base, 2) != 2) begin
            errors++;
            $display("FAIL ovr_drain got %0d events (%0d id2) want 2",
                     ev_ids.size() - base, count_id(base, 2));
        end
    endtask

    task automatic test_same_cycle();
        int base;
        int n3;
        int o[4];
        int od;
        apply_reset();
        idle(3);
        base = ev_ids.size();
        for (int i = 0; i < 4; i++) o[i] = ovr_cnt[i];
        click(0);
        click(0);
        press_at(0, n3);
        // consume the held event in the cycle the new edge pulse is high
        wait_until(n3 + 1);
        evt_ready = 1'b1;
        idle(10);
        od = 0;
        for (int i = 0; i < 4; i++) od += ovr_cnt[i] - o[i];
        checks++;
        if (od != 0) begin
            errors++;
            $display("FAIL same_ovr got %0d want 0", od);
        end
        checks++;
        if (ev_ids.size() != base + 3 || count_id(base, 0) != 3) begin
            errors++;
            $display("FAIL same_events got %0d (%0d id0) want 3",
                     ev_ids.size() - base, count_id(base, 0));
        end
        btn_in[0] = 1'b0;
        idle(30);
    endtask

    task automatic test_reset_mid();
        int base;
        apply_reset();
        idle(3);
        btn_in = 4'b0011;
        idle(25);
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got v%b want 1", evt_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0 ||
            evt_overrun !== 4'h0 || btn_level !== 4'h0) begin
            errors++;
            $display("FAIL mid_async got v%b id %0d ovr %h lvl %h want all 0",
                     evt_valid, evt_id, evt_overrun, btn_level);
        end
        btn_in = '0;
        idle(3);
        evt_ready = 1'b1;
        rst_n = 1'b1;
        base = ev_ids.size();
        idle(40);
        checks++;
        if (ev_ids.size() != base) begin
            errors++;
            $display("FAIL mid_quiet got %0d events want 0",
                     ev_ids.size() - base);
        end
        btn_in[3] = 1'b1;
        idle(25);
        checks++;
        if (ev_ids.size() != base + 1 || count_id(base, 3) != 1) begin
            errors++;
            $display("FAIL mid_newpress got %0d events (%0d id3) want 1",
                     ev_ids.size() - base, count_id(base, 3));
        end
        btn_in = '0;
        idle(30);
    endtask

    // Every debounced press either becomes an event or an overrun pulse.
    task automatic test_random();
        int base;
        int o[4];
        int presses[4];
        logic [3:0] nv;
        logic [3:0] pv;
        int len;
        apply_reset();
        idle(3);
        base = ev_ids.size();
        for (int i = 0; i < 4; i++) begin
            o[i] = ovr_cnt[i];
            presses[i] = 0;
        end
        pv = '0;
        for (int s = 0; s < 30; s++) begin
            nv = 4'($urandom % 16);
            for (int i = 0; i < 4; i++)
                if (nv[i] && !pv[i]) presses[i]++;
            btn_in = nv;
            len = $urandom_range(16, 30);
            repeat (len) begin
                evt_ready = 1'($urandom % 2);
                @(negedge clk);
            end
            pv = nv;
        end
        btn_in = '0;
        evt_ready = 1'b1;
        idle(40);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count_id(base, i) + ovr_cnt[i] - o[i] != presses[i]) begin
                errors++;
                $display("FAIL rand_btn%0d got %0d ev + %0d ovr want %0d",
                         i, count_id(base, i), ovr_cnt[i] - o[i], presses[i]);
            end
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain got v%b want 0", evt_valid);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_stable got %0d violations want 0", stall_viol);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_round_robin();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
